div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit.sv | 119 +++++++++++
 tb/tb_div_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: default operand width and FSM
// state encodings.
`timescale 1ns/1ps
package div_unit_pkg;

  localparam int DIV_W_DEF = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// EXE-stage <-> divider handshake bundle. The master is the EXE stage and stall
// controller; the slave is the divider itself.
`timescale 1ns/1ps
interface div_unit_if #(
    parameter int DIV_W = div_unit_pkg::DIV_W_DEF
);
    logic                 div_start;
    logic                 div_signed;
    logic [DIV_W-1:0]     div_opdata1;
    logic [DIV_W-1:0]     div_opdata2;
    logic                 flush;
    logic                 longest_stall;
    logic                 stallreq_exe;
    logic [2*DIV_W-1:0]   div_result;
    logic                 div_ready;

    modport master (
        output div_start, div_signed, div_opdata1, div_opdata2, flush, longest_stall,
        input  stallreq_exe, div_result, div_ready
    );

    modport slave (
        input  div_start, div_signed, div_opdata1, div_opdata2, flush, longest_stall,
        output stallreq_exe, div_result, div_ready
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, result
// {HI=remainder, LO=quotient} held in END until the pipeline is released.
`timescale 1ns/1ps
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic      cpu_clk_50M,
    input  logic      cpu_rst_n,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DIV_W + 1);

    div_state_e           state_q, state_d;
    logic [2*DIV_W:0]     work_q, work_d;
    logic [DIV_W-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*DIV_W-1:0]   result_q, result_d;

    logic                 a_neg, b_neg, by_zero;
    logic [DIV_W-1:0]     abs_a, abs_b;
    logic [DIV_W+1:0]     diff;
    logic [2*DIV_W:0]     step_work;
    logic [DIV_W-1:0]     quo, rem;

    assign a_neg   = bus.div_signed & bus.div_opdata1[DIV_W-1];
    assign b_neg   = bus.div_signed & bus.div_opdata2[DIV_W-1];
    assign abs_a   = a_neg ? -bus.div_opdata1 : bus.div_opdata1;
    assign abs_b   = b_neg ? -bus.div_opdata2 : bus.div_opdata2;
    assign by_zero = (bus.div_opdata2 == '0);

    // work = {partial remainder, remaining dividend bits, quotient bits}; the
    // trial subtract looks at the remainder plus the next dividend bit.
    assign diff      = {1'b0, work_q[2*DIV_W:DIV_W]} - {2'b00, dvs_q};
    assign step_work = diff[DIV_W+1] ? {work_q[2*DIV_W-1:0], 1'b0}
                                     : {diff[DIV_W-1:0], work_q[DIV_W-1:0], 1'b1};
    assign quo       = step_work[DIV_W-1:0];
    assign rem       = step_work[2*DIV_W:DIV_W+1];

    assign bus.stallreq_exe = cpu_rst_n & bus.div_start & ~bus.flush & (state_q != DIV_END);
    assign bus.div_ready    = (state_q == DIV_END);
    assign bus.div_result   = result_q;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= DIV_FREE;
            work_q    <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (bus.flush) begin
            state_d  = DIV_FREE;
            cnt_d    = '0;
            result_d = '0;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    result_d = '0;
                    if (bus.div_start) begin
                        cnt_d     = '0;
                        dvs_d     = abs_b;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        // Divide-by-zero parks the raw dividend here so HI is
                        // immune to operand changes after the start cycle.
                        work_d    = {{DIV_W{1'b0}}, (by_zero ? bus.div_opdata1 : abs_a), 1'b0};
                        state_d   = by_zero ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: begin
                    result_d = {work_q[DIV_W:1], {DIV_W{1'b1}}};
                    state_d  = DIV_END;
                end
                DIV_ON: begin
                    if (cnt_q == CNT_W'(DIV_W - 1)) begin
                        result_d = {(neg_rem_q ? -rem : rem), (neg_quo_q ? -quo : quo)};
                        state_d  = DIV_END;
                    end else begin
                        work_d = step_work;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
                DIV_END: begin
                    if (!bus.longest_stall) begin
                        state_d  = DIV_FREE;
                        result_d = '0;
                    end
                end
                default: state_d = DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: stimulus pushes expected results,
// a negedge monitor pops them whenever div_ready rises.
`timescale 1ns/1ps
module tb_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.DIV_W(W)) bus();

    div_unit #(.DIV_W(W)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .bus         (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division (C-style truncation), with the
    // architectural divide-by-zero convention.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    logic        prev_rdy = 1'b0;
    logic [63:0] held_res;
    logic [63:0] mon_exp;
    always @(negedge clk) begin
        if (bus.div_ready === 1'b1) begin
            if (!prev_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL result: unexpected div_ready, result %h, nothing queued", bus.div_result);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("result", bus.div_result, mon_exp);
                end
            end else begin
                check("result_hold", bus.div_result, held_res);
            end
            held_res = bus.div_result;
            check("stallreq_in_end", {63'd0, bus.stallreq_exe}, 64'd0);
        end
        prev_rdy = (bus.div_ready === 1'b1);
    end

    // One divide. If div_start is already high we are in the IDLE cycle after
    // its negedge (back-to-back), which already counted one stall cycle.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int k, input bit keep);
        int  cnt, budget, first_scr;
        bit  timeout;
        exp_q.push_back(ref_div(a, b, sgn));
        if (bus.div_start) begin
            cnt = 1;
            first_scr = 1;
        end else begin
            @(posedge clk); #1;
            cnt = 0;
            first_scr = 2;
        end
        bus.div_start     = 1'b1;
        bus.div_signed    = sgn;
        bus.div_opdata1   = a;
        bus.div_opdata2   = b;
        bus.longest_stall = (k > 0);
        budget  = 0;
        timeout = 0;
        while (1) begin
            @(negedge clk);
            budget++;
            if (bus.div_ready === 1'b1) break;
            if (bus.stallreq_exe === 1'b1) cnt++;
            if (budget > 200) begin
                timeout = 1;
                break;
            end
            if (budget >= first_scr) begin
                bus.div_opdata1 = $urandom;
                bus.div_opdata2 = $urandom;
                bus.div_signed  = 1'($urandom_range(0, 1));
            end
        end
        if (timeout) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: no div_ready after %0d cycles, expected within %0d", budget, W + 2);
            exp_q.delete();
            bus.div_start     = 1'b0;
            bus.longest_stall = 1'b0;
            return;
        end
        check("stall_cycles", 64'(cnt), (b == 32'd0) ? 64'd2 : 64'(W + 1));
        if (k > 0) begin
            repeat (k - 1) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("ready_while_stalled", {63'd0, bus.div_ready}, 64'd1);
            end
            @(posedge clk); #1;
            bus.longest_stall = 1'b0;
            @(negedge clk);
            check("ready_release_cycle", {63'd0, bus.div_ready}, 64'd1);
        end
        @(posedge clk); #1;
        if (!keep) bus.div_start = 1'b0;
        @(negedge clk);
        check("ready_drop", {63'd0, bus.div_ready}, 64'd0);
    endtask

    initial begin
        bus.div_start     = 1'b1;
        bus.div_signed    = 1'b0;
        bus.div_opdata1   = 32'd100;
        bus.div_opdata2   = 32'd7;
        bus.flush         = 1'b0;
        bus.longest_stall = 1'b0;
        #2;
        check("rst_stallreq", {63'd0, bus.stallreq_exe}, 64'd0);
        check("rst_ready", {63'd0, bus.div_ready}, 64'd0);
        check("rst_result", bus.div_result, 64'd0);
        bus.div_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, 0, 1'b0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2, 1'b0);
        do_div(32'h0000_1234, 32'd0, 1'b0, 0, 1'b0);
        do_div(32'd100, 32'd7, 1'b0, 5, 1'b1);
        do_div(32'hDEAD_BEEF, 32'd3, 1'b0, 0, 1'b0);
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0, 1'b0);

        // Flush on the tenth ON cycle, then restart with start still held.
        @(posedge clk); #1;
        bus.div_start   = 1'b1;
        bus.div_signed  = 1'b0;
        bus.div_opdata1 = 32'd100;
        bus.div_opdata2 = 32'd7;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_stallreq", {63'd0, bus.stallreq_exe}, 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("post_flush_ready", {63'd0, bus.div_ready}, 64'd0);
        do_div(32'd100, 32'd7, 1'b0, 0, 1'b0);

        // Reset in the middle of ON.
        @(posedge clk); #1;
        bus.div_start   = 1'b1;
        bus.div_opdata1 = 32'd100;
        bus.div_opdata2 = 32'd7;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_stallreq", {63'd0, bus.stallreq_exe}, 64'd0);
        check("midrst_ready", {63'd0, bus.div_ready}, 64'd0);
        check("midrst_result", bus.div_result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_stallreq", {63'd0, bus.stallreq_exe}, 64'd1);
        do_div(32'd100, 32'd7, 1'b0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            int sel;
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = 32'd0;
            else if (sel < 3)  rb = 32'($urandom_range(1, 15));
            else if (sel == 3) rb = 32'hFFFF_FFFF;
            else               rb = $urandom;
            do_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   (i != 23) && ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d results never delivered, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
